// File: rtl/access_pkg.sv
// Shared types and constants for the multi-user access controller.
// Latency: none (types, constants and a lookup helper only).
// Backpressure: not applicable.
package access_pkg;

    localparam int DEF_DATA_W         = 16;
    localparam int DEF_NUM_USERS      = 4;
    localparam int DEF_MAX_FAILS      = 3;
    localparam int DEF_LOCKOUT_CYCLES = 1024;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PW,
        ST_SEARCH,
        ST_GRANTED,
        ST_LOCKED
    } state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] id;
        logic [DEF_DATA_W-1:0] pw;
    } cred_t;

    // Populated credentials; any table slot beyond these reads as id 0 (never matches).
    localparam int CRED_TABLE_LEN = 2;
    localparam cred_t [CRED_TABLE_LEN-1:0] CRED_TABLE = {
        cred_t'{id: 16'hAAAA, pw: 16'h5555},
        cred_t'{id: 16'h1476, pw: 16'h2456}
    };

    function automatic cred_t cred_entry(input int idx);
        cred_t e;
        e = '0;
        if (idx >= 0 && idx < CRED_TABLE_LEN) begin
            e = CRED_TABLE[idx];
        end
        return e;
    endfunction

endpackage

// File: rtl/access_cred_rom.sv
// Credential table, NUM_USERS entries, looked up by index.
// Latency: 1 cycle (registered read data).
// Backpressure: none; a new index can be presented every cycle.
module access_cred_rom
    import access_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int NUM_USERS = DEF_NUM_USERS,
    parameter int IDX_W     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_id,
    output logic [DATA_W-1:0] rd_pw
);

    cred_t entry;

    // Out-of-range indices read as an empty slot so the search can run past the end harmlessly.
    always_comb begin
        entry = '0;
        if (int'(rd_idx) < NUM_USERS) begin
            entry = cred_entry(int'(rd_idx));
        end
    end

    // Registered read port.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_id <= '0;
            rd_pw <= '0;
        end else begin
            rd_id <= DATA_W'(entry.id);
            rd_pw <= DATA_W'(entry.pw);
        end
    end

endmodule

// File: rtl/access_control_multi.sv
// Two-phase (ID, then password) login against a credential table, with explicit logout.
// Latency: grant for entry i at T0+2+i after the password strobe edge T0; denial at T0+NUM_USERS+1.
// Backpressure: none; strobes arriving in SEARCH/GRANTED/LOCKED are dropped. ACCESS_LOCKOUT_EN adds lockout.
module access_control_multi
    import access_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int NUM_USERS      = DEF_NUM_USERS,
    parameter int UID_W          = (NUM_USERS > 1) ? $clog2(NUM_USERS) : 1,
    parameter int MAX_FAILS      = DEF_MAX_FAILS,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_in_load,
    input  logic              logout,
    output logic              access_grant,
    output logic [UID_W-1:0]  user_id,
    output logic              busy,
    output logic              denied,
    output logic              locked
);

`ifdef ACCESS_LOCKOUT_EN
    localparam bit LOCKOUT_EN = 1'b1;
`else
    localparam bit LOCKOUT_EN = 1'b0;
`endif

    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int TMR_W  = $clog2(LOCKOUT_CYCLES + 1);

    state_t              state;
    logic                load_q;
    logic                load_edge;
    logic [DATA_W-1:0]   id_r;
    logic [DATA_W-1:0]   pw_r;
    logic [UID_W-1:0]    idx;
    logic [UID_W-1:0]    cmp_idx;
    logic                cmp_vld;
    logic [DATA_W-1:0]   rom_id;
    logic [DATA_W-1:0]   rom_pw;
    logic                match;
    logic                last_entry;
    logic [FAIL_W-1:0]   fail_cnt;
    logic [TMR_W-1:0]    lock_tmr;

    access_cred_rom #(
        .DATA_W    (DATA_W),
        .NUM_USERS (NUM_USERS),
        .IDX_W     (UID_W)
    ) u_rom (
        .clk    (clk),
        .rst    (rst),
        .rd_idx (idx),
        .rd_id  (rom_id),
        .rd_pw  (rom_pw)
    );

    // Strobe edge and comparison of the entry currently presented by the table (id 0 is a blank slot).
    always_comb begin
        load_edge  = data_in_load & ~load_q;
        match      = (rom_id != '0) && (rom_id == id_r) && (rom_pw == pw_r);
        last_entry = (cmp_idx == UID_W'(NUM_USERS - 1));
    end

    // Session FSM with registered outputs; cmp_idx tags the table entry arriving one cycle after idx.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            load_q       <= 1'b0;
            id_r         <= '0;
            pw_r         <= '0;
            idx          <= '0;
            cmp_idx      <= '0;
            cmp_vld      <= 1'b0;
            fail_cnt     <= '0;
            lock_tmr     <= '0;
            access_grant <= 1'b0;
            user_id      <= '0;
            busy         <= 1'b0;
            denied       <= 1'b0;
            locked       <= 1'b0;
        end else begin
            load_q <= data_in_load;
            denied <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (load_edge) begin
                        id_r  <= data_in;
                        state <= ST_WAIT_PW;
                    end
                end
                ST_WAIT_PW: begin
                    if (load_edge) begin
                        pw_r    <= data_in;
                        idx     <= '0;
                        cmp_vld <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    idx     <= idx + 1'b1;
                    cmp_idx <= idx;
                    cmp_vld <= 1'b1;
                    if (cmp_vld && match) begin
                        access_grant <= 1'b1;
                        user_id      <= cmp_idx;
                        busy         <= 1'b0;
                        fail_cnt     <= '0;
                        state        <= ST_GRANTED;
                    end else if (cmp_vld && last_entry) begin
                        denied <= 1'b1;
                        busy   <= 1'b0;
                        state  <= ST_IDLE;
                        if (LOCKOUT_EN) begin
                            if (int'(fail_cnt) < MAX_FAILS) begin
                                fail_cnt <= fail_cnt + 1'b1;
                            end
                            if (int'(fail_cnt) + 1 >= MAX_FAILS) begin
                                locked   <= 1'b1;
                                lock_tmr <= '0;
                                state    <= ST_LOCKED;
                            end
                        end
                    end
                end
                ST_GRANTED: begin
                    if (logout) begin
                        access_grant <= 1'b0;
                        user_id      <= '0;
                        state        <= ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (lock_tmr == TMR_W'(LOCKOUT_CYCLES - 1)) begin
                        locked   <= 1'b0;
                        fail_cnt <= '0;
                        lock_tmr <= '0;
                        state    <= ST_IDLE;
                    end else begin
                        lock_tmr <= lock_tmr + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_access_control_multi.sv
// Bench for access_control_multi: directed scenarios plus randomized logins, scoreboarded.
// Outcomes (grant/deny, user, cycle) come from a table-scan reference model and are
// checked by an independent monitor; direct checks cover levels around each outcome.
module tb_access_control_multi;

    localparam int DATA_W         = 16;
    localparam int NUM_USERS      = 4;
    localparam int UID_W          = 2;
    localparam int MAX_FAILS      = 3;
    localparam int LOCKOUT_CYCLES = 1024;
`ifdef ACCESS_LOCKOUT_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [DATA_W-1:0] data_in = '0;
    logic              data_in_load = 1'b0;
    logic              logout = 1'b0;
    logic              access_grant;
    logic [UID_W-1:0]  user_id;
    logic              busy;
    logic              denied;
    logic              locked;

    access_control_multi dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_in_load (data_in_load),
        .logout       (logout),
        .access_grant (access_grant),
        .user_id      (user_id),
        .busy         (busy),
        .denied       (denied),
        .locked       (locked)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        bit is_grant;
        int uid;
        int at;
    } exp_t;
    exp_t expq[$];

    logic [DATA_W-1:0] ref_id [NUM_USERS] = '{16'h1476, 16'hAAAA, 16'h0000, 16'h0000};
    logic [DATA_W-1:0] ref_pw [NUM_USERS] = '{16'h2456, 16'h5555, 16'h0000, 16'h0000};
    int fails = 0;
    bit mon_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // First table entry (blank id excluded) equal to both words wins; scan ends after the last entry.
    function automatic exp_t model(input logic [DATA_W-1:0] id, input logic [DATA_W-1:0] pw, input int t0);
        exp_t e;
        e.is_grant = 1'b0;
        e.uid      = 0;
        e.at       = t0 + NUM_USERS + 1;
        for (int i = NUM_USERS - 1; i >= 0; i--) begin
            if (ref_id[i] != 0 && ref_id[i] == id && ref_pw[i] == pw) begin
                e.is_grant = 1'b1;
                e.uid      = i;
                e.at       = t0 + 2 + i;
            end
        end
        return e;
    endfunction

    task automatic report_event(input bit g, input int uid);
        exp_t e;
        vectors++;
        if (expq.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_event: grant=%0d uid=%0d at cycle %0d, none expected", g, uid, cyc);
        end else begin
            e = expq.pop_front();
            if (e.is_grant != g || e.uid != uid || e.at != cyc) begin
                miscompares++;
                $display("FAIL outcome: got grant=%0d uid=%0d cycle=%0d, expected grant=%0d uid=%0d cycle=%0d",
                         g, uid, cyc, e.is_grant, e.uid, e.at);
            end
        end
    endtask

    // Monitor: every grant rising edge and every denied-high cycle is an outcome to match.
    initial begin
        forever begin
            @(negedge clk);
            if (access_grant && !mon_prev) report_event(1'b1, int'(user_id));
            if (denied) report_event(1'b0, 0);
            mon_prev = access_grant;
        end
    end

    task automatic lockout_phase(input int d);
        chk("locked_set", locked, 1);
        @(negedge clk); data_in = 16'h1476; data_in_load = 1'b1;
        @(negedge clk); data_in_load = 1'b0;
        @(negedge clk); data_in = 16'h2456; data_in_load = 1'b1;
        @(negedge clk); data_in_load = 1'b0;
        chk("busy_while_locked", busy, 0);
        while (cyc < d + LOCKOUT_CYCLES - 1) @(negedge clk);
        chk("locked_last_cycle", locked, 1);
        @(negedge clk);
        chk("locked_released", locked, 0);
        fails = 0;
    endtask

    task automatic run_txn(input logic [DATA_W-1:0] id, input logic [DATA_W-1:0] pw,
                           input bit hold_id, input bit search_load,
                           input bit granted_load, input bit logout_with_load);
        exp_t e;
        int t0;
        @(negedge clk); data_in = id; data_in_load = 1'b1;
        if (hold_id) begin
            for (int k = 0; k < 4; k++) begin
                @(negedge clk); data_in = DATA_W'($urandom);
            end
        end
        @(negedge clk); data_in_load = 1'b0; data_in = DATA_W'($urandom);
        @(negedge clk); data_in = pw; data_in_load = 1'b1; t0 = cyc + 1;
        e = model(id, pw, t0);
        expq.push_back(e);
        @(negedge clk); data_in_load = 1'b0;
        chk("busy_in_search", busy, 1);
        if (search_load) begin
            @(negedge clk); data_in = DATA_W'($urandom); data_in_load = 1'b1;
            @(negedge clk); data_in_load = 1'b0;
        end
        while (cyc < e.at + 1) @(negedge clk);
        chk("scoreboard_drained", expq.size(), 0);
        expq.delete();
        chk("denied_one_cycle", denied, 0);
        chk("busy_done", busy, 0);
        if (e.is_grant) begin
            fails = 0;
            chk("grant_held", access_grant, 1);
            chk("user_id_held", user_id, e.uid);
            if (granted_load) begin
                data_in = DATA_W'($urandom); data_in_load = 1'b1;
                @(negedge clk); data_in_load = 1'b0;
                chk("grant_after_load", access_grant, 1);
                chk("user_id_after_load", user_id, e.uid);
                @(negedge clk);
            end
            logout = 1'b1;
            if (logout_with_load) begin
                data_in = DATA_W'($urandom); data_in_load = 1'b1;
            end
            @(negedge clk); logout = 1'b0; data_in_load = 1'b0;
            chk("grant_after_logout", access_grant, 0);
            chk("user_id_after_logout", user_id, 0);
        end else begin
            chk("grant_on_deny", access_grant, 0);
            chk("user_id_on_deny", user_id, 0);
            if (LOCK_EN) begin
                fails++;
                if (fails >= MAX_FAILS) lockout_phase(e.at);
                else chk("locked_low", locked, 0);
            end else begin
                chk("locked_low", locked, 0);
            end
        end
    endtask

    task automatic reset_mid_search();
        @(negedge clk); data_in = 16'hAAAA; data_in_load = 1'b1;
        @(negedge clk); data_in_load = 1'b0;
        @(negedge clk); data_in = 16'h5555; data_in_load = 1'b1;
        @(negedge clk); data_in_load = 1'b0;
        chk("busy_before_reset", busy, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst_grant", access_grant, 0);
        chk("rst_user_id", user_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_denied", denied, 0);
        chk("rst_locked", locked, 0);
        @(negedge clk);
        @(negedge clk); rst = 1'b1; fails = 0;
        repeat (8) @(negedge clk);
        chk("no_grant_after_reset", access_grant, 0);
    endtask

    logic [DATA_W-1:0] rid;
    logic [DATA_W-1:0] rpw;
    int sel;

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_grant", access_grant, 0);
        chk("reset_user_id", user_id, 0);
        chk("reset_busy", busy, 0);
        chk("reset_denied", denied, 0);
        chk("reset_locked", locked, 0);
        rst = 1'b1;
        @(negedge clk);

        run_txn(16'h1476, 16'h2456, 0, 0, 0, 0);
        run_txn(16'hAAAA, 16'h5555, 0, 0, 0, 0);
        run_txn(16'h1476, 16'h0000, 0, 0, 0, 0);
        run_txn(16'h1476, 16'h2456, 1, 1, 1, 0);
        run_txn(16'hAAAA, 16'h5555, 0, 1, 0, 0);
        run_txn(16'h0000, 16'h0000, 0, 0, 0, 0);
        reset_mid_search();
        run_txn(16'hAAAA, 16'h5555, 0, 0, 0, 1);
        run_txn(16'h1476, 16'h2456, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) run_txn(16'hAAAA, 16'h1234, 0, 0, 0, 0);
        run_txn(16'hAAAA, 16'h5555, 0, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0: begin rid = 16'h1476; rpw = 16'h2456; end
                1: begin rid = 16'hAAAA; rpw = 16'h5555; end
                2: begin rid = 16'h1476; rpw = DATA_W'($urandom); end
                3: begin rid = DATA_W'($urandom); rpw = DATA_W'($urandom); end
                4: begin rid = 16'h0000; rpw = 16'h0000; end
                default: begin rid = 16'hAAAA; rpw = 16'h2456; end
            endcase
            run_txn(rid, rpw, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
